// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream loader that fills instruction memory and holds the CPU until done
//
// Purpose: assembles a little-endian byte stream into 32-bit instructions and
// writes them to consecutive word addresses starting at BASE_ADDR. The CPU is
// held in reset (cpu_hold) until the whole image has been committed.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   in_valid/in_byte/in_last/in_ready   byte stream handshake
//   mem_wr_en/mem_wr_addr/mem_wr_data/mem_wr_ready   memory write handshake
//   cpu_hold            high until the load completes
//   done                load complete (terminal until reset)
//   word_count          words committed to memory, saturates at MAX_WORDS
//   error               sticky: truncated last word or overflow
module instr_mem_loader #(
    parameter int              WORD      = 64,
    parameter int              INSTR_LEN = 32,
    parameter int              MAX_WORDS = 256,
    parameter logic [WORD-1:0] BASE_ADDR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_byte,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 mem_wr_en,
    output logic [WORD-1:0]      mem_wr_addr,
    output logic [INSTR_LEN-1:0] mem_wr_data,
    input  logic                 mem_wr_ready,
    output logic                 cpu_hold,
    output logic                 done,
    output logic [15:0]          word_count,
    output logic                 error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSEMBLE,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

    state_t                 state_q, state_d;
    logic [1:0]             idx_q, idx_d;
    logic [INSTR_LEN-1:0]   data_q, data_d;
    logic [WORD-1:0]        addr_q, addr_d;
    logic [15:0]            count_q, count_d;
    logic                   err_q, err_d;
    logic                   last_q, last_d;
    logic                   full;

    assign full = (count_q == MAX_COUNT);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_ASSEMBLE;
            end

            S_ASSEMBLE: begin
                if (in_valid) begin
                    if (full) begin
                        // Memory is full: swallow the rest of the image so the
                        // source can finish, but flag it.
                        err_d = 1'b1;
                        if (in_last) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        // Byte 0 clears the word so a truncated word is zero-filled.
                        if (idx_q == 2'd0) begin
                            data_d = '0;
                        end
                        data_d[{idx_q, 3'b000} +: 8] = in_byte;
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3 || in_last) begin
                            state_d = S_WRITE;
                            last_d  = in_last;
                            if (in_last && idx_q != 2'd3) begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
            end

            S_WRITE: begin
                if (mem_wr_ready) begin
                    count_d = full ? count_q : count_q + 16'd1;
                    addr_d  = addr_q + WORD'(4);
                    idx_d   = 2'd0;
                    state_d = last_q ? S_DONE : S_ASSEMBLE;
                end
            end

            default: begin
                state_d = S_DONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            data_q  <= '0;
            addr_q  <= BASE_ADDR;
            count_q <= 16'd0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    // Outputs decode straight from the state register so that reset drops
    // mem_wr_en and raises cpu_hold immediately, and cpu_hold falls in the
    // same cycle DONE is entered.
    assign in_ready    = (state_q == S_ASSEMBLE);
    assign mem_wr_en   = (state_q == S_WRITE);
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = data_q;
    assign cpu_hold    = (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign word_count  = count_q;
    assign error       = err_q;

endmodule
